uart_frame_tx: RTL
==================

# uart_frame_tx

Response framer on the transmit side of the host link. Accepts one fixed-size result message from the cracking core (e.g. a matched candidate), wraps it as a sync/length/payload/checksum frame, and feeds it byte-by-byte into the `uart` transmitter through its `tx_byte`/`tx_req`/`tx_busy` interface. It is the initiator on the interface that `uart` serves.

## Interface
- `PAYLOAD_BYTES`, 8: payload bytes per frame, 1..255.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.
- `ACK_TIMEOUT`, 64: cycles to wait for `tx_busy` to rise after raising `tx_req` before aborting the frame, at least 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `msg_data`  in  8*PAYLOAD_BYTES  payload. Byte 0 is `msg_data[7:0]` and is sent first.
- `msg_valid`  in  1  payload offered.
- `msg_ready`  out  1  framer idle and able to accept.
- `tx_byte`  out  8  byte to the uart.
- `tx_req`  out  1  transmit request to the uart.
- `tx_busy`  in  1  uart transmitting.
- `frame_busy`  out  1  frame in progress.
- `frame_err`  out  1  one-cycle pulse when a frame is aborted on timeout.
- `frames_sent`  out  16  count of completed frames. Wraps at 16'hFFFF to 0.

## Operation
- Frame order:
  - `SYNC_BYTE`
  - `LEN`, equal to `PAYLOAD_BYTES[7:0]`
  - payload bytes 0..N-1
  - `CHK`, the 8-bit XOR of `LEN` and all payload bytes.
- States are IDLE, LOAD, REQ, DRAIN and NEXT.
- IDLE:
  - `msg_ready` = 1.
  - When `msg_valid` & `msg_ready`: capture `msg_data` into an internal register, clear the byte index and the running XOR, then go to LOAD.
  - `msg_data` is ignored at all other times.
- LOAD: drive `tx_byte` with the current frame byte, then go to REQ.
- REQ:
  - `tx_req` = 1 and `tx_byte` is held.
  - If `tx_busy` = 1, go to DRAIN.
  - Otherwise the timeout counter increments. When it reaches `ACK_TIMEOUT`, pulse `frame_err`, discard the frame and go to IDLE.
- DRAIN:
  - `tx_req` = 0 and `tx_byte` is held.
  - When `tx_busy` = 0, go to NEXT.
- NEXT:
  - Fold the sent payload or `LEN` byte into the XOR and advance the index.
  - If the byte just sent was `CHK`: increment `frames_sent` and go to IDLE.
  - Otherwise go to LOAD.
- `frame_busy` = 1 in every state except IDLE.
- The timeout counter clears on entry to REQ. It is only active in REQ.
- If `tx_busy` is already 1 on entry to REQ (uart still finishing an external byte), that counts as acknowledge. The framer then waits in DRAIN, so no byte is lost. The same edge case is exercised by the tests.
- The index width is ceil(log2(PAYLOAD_BYTES+3)).
- Reset mid-frame returns the block to IDLE immediately. No partial-frame completion and no `frame_err` pulse.

## Timing
- Reset values:
  - `msg_ready` = 1
  - `tx_req` = 0
  - `tx_byte` = 8'h00
  - `frame_busy` = 0
  - `frame_err` = 0
  - `frames_sent` = 0
- All outputs are registered.
- Accept handshake at clock edge T0:
  - `msg_ready` = 0 from T0+1.
  - `tx_byte` = `SYNC_BYTE` from T0+2.
  - `tx_req` = 1 from T0+2.
- `tx_req` falls on the cycle after `tx_busy` is sampled high.
- `tx_byte` is stable from LOAD until DRAIN exits.
- Per-byte overhead beyond the uart character time is 3 cycles: LOAD, NEXT and the `tx_busy`-sample cycle.
- Completion:
  - The `frames_sent` increment and `msg_ready` = 1 occur together, one cycle after `tx_busy` falls for `CHK`.
  - A new message may be accepted in that same cycle.
- `frame_err` is exactly one cycle wide and coincides with `msg_ready` returning to 1.

## Test plan
- Single frame, default parameters, with the uart RX looped back:
  - `msg_data` = 64'h0706050403020100 -> received bytes A5 08 00 01 02 03 04 05 06 07 08.
  - `CHK` = 8'h08, which is the XOR of 08 with 00..07.
  - `frames_sent` = 1.
- Back-to-back frames:
  - `msg_valid` is held high with two different payloads -> the second frame's `SYNC` starts only after the first `CHK` completes.
  - No byte is duplicated or dropped.
  - `frames_sent` = 2.
- Timeout:
  - Stub `tx_busy` tied 0 -> `tx_req` stays high for 64 cycles.
  - Then one `frame_err` pulse, `tx_req` = 0 and `msg_ready` = 1.
  - `frames_sent` is unchanged.
- `tx_busy` already high when REQ is entered:
  - The stub holds `tx_busy` = 1 for 100 cycles and then drops it -> the framer waits in DRAIN.
  - `tx_req` is asserted for exactly 1 cycle.
  - The next byte follows.
- Reset mid-frame:
  - Assert `reset` (low) during payload byte 3 -> all outputs are at their reset values within the same cycle.
  - After release, a new frame starts cleanly with A5.
- Wrap:
  - Preload or force 16'hFFFF completed frames, then send one more -> `frames_sent` = 16'h0000.

Source files
------------

// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//
// Transmit-side response framer for the host link. Takes one fixed-size result
// message and sends it to the uart transmitter as
//     SYNC_BYTE, LEN, payload[0..N-1], CHK
// where LEN = PAYLOAD_BYTES[7:0] and CHK is the XOR of LEN and every payload
// byte. Each byte is handed over with a tx_req / tx_busy handshake: tx_req is
// held until the uart shows tx_busy, then the framer waits for tx_busy to drop
// before moving on. If tx_busy never rises within ACK_TIMEOUT cycles, the frame
// is dropped and frame_err pulses for one cycle.
//
// Parameters:
//   PAYLOAD_BYTES  payload bytes per frame, 1..255
//   SYNC_BYTE      first byte of every frame
//   ACK_TIMEOUT    cycles to wait for tx_busy after raising tx_req, >= 2
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous reset, active low
//   msg_data     in   payload, byte 0 = msg_data[7:0], sent first
//   msg_valid    in   payload offered
//   msg_ready    out  framer idle and able to accept
//   tx_byte      out  byte to the uart
//   tx_req       out  transmit request to the uart
//   tx_busy      in   uart transmitting
//   frame_busy   out  frame in progress
//   frame_err    out  one-cycle pulse when a frame is aborted on timeout
//   frames_sent  out  completed frame count, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int unsigned PAYLOAD_BYTES = 8,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned ACK_TIMEOUT   = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [8*PAYLOAD_BYTES-1:0] msg_data,
    input  logic                       msg_valid,
    output logic                       msg_ready,
    output logic [7:0]                 tx_byte,
    output logic                       tx_req,
    input  logic                       tx_busy,
    output logic                       frame_busy,
    output logic                       frame_err,
    output logic [15:0]                frames_sent
);

    // Frame index: 0 = SYNC, 1 = LEN, 2..N+1 = payload, N+2 = CHK.
    localparam int unsigned IDX_W = $clog2(PAYLOAD_BYTES + 3);
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_SYNC = '0;
    localparam logic [IDX_W-1:0] IDX_LEN  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(PAYLOAD_BYTES + 2);
    localparam logic [7:0]       LEN_BYTE = 8'(PAYLOAD_BYTES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_DRAIN,
        S_NEXT
    } state_t;

    state_t                     state_q, state_d;
    logic [8*PAYLOAD_BYTES-1:0] msg_q, msg_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [7:0]                 xor_q, xor_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic [7:0]                 tx_byte_q, tx_byte_d;
    logic                       tx_req_q, tx_req_d;
    logic                       msg_ready_q, msg_ready_d;
    logic                       frame_busy_q, frame_busy_d;
    logic                       frame_err_q, frame_err_d;
    logic [15:0]                frames_sent_q, frames_sent_d;

    logic [7:0]                 cur_byte;
    logic                       idx_is_payload;

    // The payload register shifts right after each payload byte goes out, so
    // the byte due next always sits in msg_q[7:0] and no variable index is
    // needed into the message.
    assign idx_is_payload = (idx_q > IDX_LEN) && (idx_q < IDX_CHK);

    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first); a missed branch would otherwise infer a latch.
    always_comb begin
        cur_byte = msg_q[7:0];
        if (idx_q == IDX_SYNC) begin
            cur_byte = SYNC_BYTE;
        end else if (idx_q == IDX_LEN) begin
            cur_byte = LEN_BYTE;
        end else if (idx_q == IDX_CHK) begin
            cur_byte = xor_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        msg_d         = msg_q;
        idx_d         = idx_q;
        xor_d         = xor_q;
        tmo_d         = tmo_q;
        tx_byte_d     = tx_byte_q;
        tx_req_d      = tx_req_q;
        frame_err_d   = 1'b0;
        frames_sent_d = frames_sent_q;

        unique case (state_q)
            S_IDLE: begin
                if (msg_valid && msg_ready_q) begin
                    msg_d   = msg_data;
                    idx_d   = IDX_SYNC;
                    xor_d   = 8'h00;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                tx_byte_d = cur_byte;
                tx_req_d  = 1'b1;
                tmo_d     = '0;
                state_d   = S_REQ;
            end

            S_REQ: begin
                // A uart still busy with an earlier byte on entry counts as
                // the acknowledge; DRAIN then waits it out before moving on.
                if (tx_busy) begin
                    tx_req_d = 1'b0;
                    state_d  = S_DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    tx_req_d    = 1'b0;
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_DRAIN: begin
                if (!tx_busy) begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                if (idx_q == IDX_CHK) begin
                    frames_sent_d = frames_sent_q + 16'd1;
                    state_d       = S_IDLE;
                end else begin
                    // tx_byte_q still holds the byte just sent; SYNC is not
                    // part of the checksum.
                    if (idx_q != IDX_SYNC) begin
                        xor_d = xor_q ^ tx_byte_q;
                    end
                    if (idx_is_payload) begin
                        msg_d = msg_q >> 8;
                    end
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        msg_ready_d  = (state_d == S_IDLE);
        frame_busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the payload register is reset along with the control state; it is
    // small, and a defined value keeps tx_byte and CHK free of X after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            msg_q         <= '0;
            idx_q         <= '0;
            xor_q         <= 8'h00;
            tmo_q         <= '0;
            tx_byte_q     <= 8'h00;
            tx_req_q      <= 1'b0;
            msg_ready_q   <= 1'b1;
            frame_busy_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frames_sent_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            msg_q         <= msg_d;
            idx_q         <= idx_d;
            xor_q         <= xor_d;
            tmo_q         <= tmo_d;
            tx_byte_q     <= tx_byte_d;
            tx_req_q      <= tx_req_d;
            msg_ready_q   <= msg_ready_d;
            frame_busy_q  <= frame_busy_d;
            frame_err_q   <= frame_err_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign msg_ready   = msg_ready_q;
    assign tx_byte     = tx_byte_q;
    assign tx_req      = tx_req_q;
    assign frame_busy  = frame_busy_q;
    assign frame_err   = frame_err_q;
    assign frames_sent = frames_sent_q;

endmodule
